// File: rtl/dac_sweep_pkg.sv
// ============================================================================
// Module      : dac_sweep_pkg
// Description : Shared types and default constants for the DAC threshold sweep.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dac_sweep_pkg;

  localparam int STEP_W        = 4;
  localparam int c_DEF_NSTEPS  = 9;
  localparam int c_DEF_SETTLE  = 16;
  localparam int c_DEF_DWELL   = 1024;
  localparam int c_DEF_CW      = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLR    = 3'd1,
    ST_LOAD   = 3'd2,
    ST_SETTLE = 3'd3,
    ST_MEAS   = 3'd4,
    ST_REPORT = 3'd5,
    ST_DONE   = 3'd6
  } state_t;

endpackage

`default_nettype wire

// File: rtl/dac_sweep_ctrl_if.sv
// ============================================================================
// Module      : dac_sweep_ctrl_if
// Description : Result valid/ready channel from the sweep sequencer to readout.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dac_sweep_ctrl_if #(
  parameter int CW = 16
);
  import dac_sweep_pkg::*;

  logic              res_valid;
  logic              res_ready;
  logic [STEP_W-1:0] res_step;
  logic [CW-1:0]     res_count;

  modport master (output res_valid, output res_step, output res_count, input res_ready);
  modport slave  (input res_valid, input res_step, input res_count, output res_ready);

endinterface

`default_nettype wire

// File: rtl/dac_sweep_ctrl_hit_edge_counter.sv
// ============================================================================
// Module      : hit_edge_counter
// Description : Rising-edge detector on hit_in feeding a saturating counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hit_edge_counter #(
  parameter int CW = 16
) (
  input  wire logic          Clk,
  input  wire logic          resn,
  input  wire logic          hit_in,
  input  wire logic          clr,
  input  wire logic          en,
  output logic [CW-1:0]      count
);

  localparam logic [CW-1:0] c_MAX = '1;

  logic          r_hit_d;
  logic [CW-1:0] r_count;
  logic          w_edge;

  assign w_edge = hit_in & ~r_hit_d;

  // The delayed copy runs in every state so a level already high at window
  // entry does not register as a fresh edge.
  always_ff @(posedge Clk) begin
    if (!resn) begin
      r_hit_d <= 1'b0;
      r_count <= '0;
    end else begin
      r_hit_d <= hit_in;
      if (clr) begin
        r_count <= '0;
      end else if (en && w_edge && (r_count != c_MAX)) begin
        r_count <= r_count + 1'b1;
      end
    end
  end

  assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/dac_sweep_ctrl.sv
// ============================================================================
// Module      : dac_sweep_ctrl
// Description : DAC threshold sweep sequencer for TDC calibration; optional
//               continuous looping enabled by DACSWEEP_LOOP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dac_sweep_ctrl
  import dac_sweep_pkg::*;
#(
  parameter int NSTEPS = c_DEF_NSTEPS,
  parameter int SETTLE = c_DEF_SETTLE,
  parameter int DWELL  = c_DEF_DWELL,
  parameter int CW     = c_DEF_CW
) (
  input  wire logic        Clk,
  input  wire logic        resn,
  input  wire logic        start,
  input  wire logic        abort,
  input  wire logic        hit_in,
  output logic             resdac,
  output logic             loaddac,
  output logic             sel_dac,
  output logic             busy,
  output logic             done,
  dac_sweep_ctrl_if.master res_if
);

  localparam int                c_TMAX      = (SETTLE > DWELL) ? SETTLE : DWELL;
  localparam int                TW          = $clog2(c_TMAX + 1);
  localparam logic [TW-1:0]     c_SETTLE_LD = TW'(SETTLE - 1);
  localparam logic [TW-1:0]     c_DWELL_LD  = TW'(DWELL - 1);
  localparam logic [STEP_W-1:0] c_LAST      = STEP_W'(NSTEPS);

  state_t            r_state;
  state_t            w_next;
  logic [TW-1:0]     r_timer;
  logic [STEP_W-1:0] r_step;
  logic              w_res_valid;
  logic [CW-1:0]     w_count;

  always_ff @(posedge Clk) begin
    if (!resn) begin
      r_state <= ST_IDLE;
      r_timer <= '0;
      r_step  <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        ST_CLR:    r_step <= '0;
        ST_LOAD: begin
          r_step  <= r_step + 1'b1;
          r_timer <= c_SETTLE_LD;
        end
        // Timer is reused: the settle expiry reloads it for the dwell window.
        ST_SETTLE: r_timer <= (r_timer == '0) ? c_DWELL_LD : r_timer - 1'b1;
        ST_MEAS:   if (r_timer != '0) r_timer <= r_timer - 1'b1;
        default:   ;
      endcase
    end
  end

  always_comb begin
    w_next      = r_state;
    resdac      = 1'b0;
    loaddac     = 1'b0;
    done        = 1'b0;
    sel_dac     = 1'b1;
    busy        = 1'b1;
    w_res_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) w_next = ST_CLR;
      end
      ST_CLR: begin
        resdac = 1'b1;
        w_next = ST_LOAD;
      end
      ST_LOAD: begin
        loaddac = 1'b1;
        w_next  = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (r_timer == '0) w_next = ST_MEAS;
      end
      ST_MEAS: begin
        sel_dac = 1'b0;
        if (r_timer == '0) w_next = ST_REPORT;
      end
      ST_REPORT: begin
        sel_dac     = 1'b0;
        w_res_valid = 1'b1;
        if (res_if.res_ready) w_next = (r_step < c_LAST) ? ST_LOAD : ST_DONE;
      end
      ST_DONE: begin
        done = 1'b1;
`ifdef DACSWEEP_LOOP_EN
        w_next = ST_CLR;
`else
        w_next = ST_IDLE;
`endif
      end
      default: w_next = ST_IDLE;
    endcase
    // Abort overrides every transition and suppresses this cycle's pulses.
    if (abort && (r_state != ST_IDLE)) begin
      w_next  = ST_IDLE;
      resdac  = 1'b0;
      loaddac = 1'b0;
      done    = 1'b0;
    end
  end

  hit_edge_counter #(.CW(CW)) u_hit_cnt (
    .Clk    (Clk),
    .resn   (resn),
    .hit_in (hit_in),
    .clr    (r_state == ST_LOAD),
    .en     (r_state == ST_MEAS),
    .count  (w_count)
  );

  assign res_if.res_valid = w_res_valid;
  assign res_if.res_step  = r_step;
  assign res_if.res_count = w_count;

endmodule

`default_nettype wire

// File: tb/tb_dac_sweep_ctrl.sv
// ============================================================================
// Module      : tb_dac_sweep_ctrl
// Description : Self-checking bench for dac_sweep_ctrl with a result scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dac_sweep_ctrl;

  typedef struct packed {
    logic [3:0] step;
    logic [3:0] count;
  } exp_t;

  logic Clk = 1'b0;
  logic resn, start, abort;
  logic resdac, loaddac, sel_dac, busy, done;
  logic sat_start, sat_abort;
  logic sat_resdac, sat_loaddac, sat_sel_dac, sat_busy, sat_done;
  logic tog = 1'b0;
  int   hit_mode = 0;
  wire  hit_in;

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   last_acc = -10;
  exp_t sb_q[$];

  assign hit_in = (hit_mode == 1) ? tog : (hit_mode == 2);

  always #5 Clk = ~Clk;

  dac_sweep_ctrl_if #(.CW(4)) res_if ();
  dac_sweep_ctrl_if #(.CW(4)) sat_if ();

  dac_sweep_ctrl #(.NSTEPS(3), .SETTLE(2), .DWELL(8), .CW(4)) u_dut (
    .Clk(Clk), .resn(resn), .start(start), .abort(abort), .hit_in(hit_in),
    .resdac(resdac), .loaddac(loaddac), .sel_dac(sel_dac), .busy(busy),
    .done(done), .res_if(res_if)
  );

  dac_sweep_ctrl #(.NSTEPS(1), .SETTLE(2), .DWELL(40), .CW(4)) u_sat (
    .Clk(Clk), .resn(resn), .start(sat_start), .abort(sat_abort), .hit_in(hit_in),
    .resdac(sat_resdac), .loaddac(sat_loaddac), .sel_dac(sat_sel_dac), .busy(sat_busy),
    .done(sat_done), .res_if(sat_if)
  );

  // One clock of progress; inputs are final here, so a handshake seen now is
  // the transfer the next edge performs and the scoreboard retires it.
  task automatic tick();
    exp_t e;
    if (resn === 1'b1 && res_if.res_valid === 1'b1 && res_if.res_ready === 1'b1 && abort === 1'b0) begin
      last_acc = cyc;
      n_vec++;
      if (sb_q.size() == 0) begin
        n_err++;
        $display("FAIL sb_unexpected: got step=%0d count=%0d, required no result", res_if.res_step, res_if.res_count);
      end else begin
        e = sb_q.pop_front();
        if (res_if.res_step !== e.step || res_if.res_count !== e.count) begin
          n_err++;
          $display("FAIL sb_result: got step=%0d count=%0d, required step=%0d count=%0d",
                   res_if.res_step, res_if.res_count, e.step, e.count);
        end
      end
    end
    @(negedge Clk);
    cyc++;
    tog = ~tog;
  endtask

  task automatic wait_sig(input int which, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tick();
      case (which)
        0:       ok = (loaddac === 1'b1);
        1:       ok = (done === 1'b1);
        2:       ok = (res_if.res_valid === 1'b1);
        default: ok = (sat_if.res_valid === 1'b1);
      endcase
      if (ok) break;
    end
  endtask

  task automatic end_sweep();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic test_reset();
    resn = 1'b0; start = 1'b0; abort = 1'b0; res_if.res_ready = 1'b0;
    sat_start = 1'b0; sat_abort = 1'b0; sat_if.res_ready = 1'b0; hit_mode = 0;
    repeat (3) tick();
    n_vec++;
    if ({resdac, loaddac, sel_dac, busy, done, res_if.res_valid} !== 6'b001000) begin
      n_err++;
      $display("FAIL rst_ctrl: got %b, required 001000", {resdac, loaddac, sel_dac, busy, done, res_if.res_valid});
    end
    n_vec++;
    if (res_if.res_step !== 4'd0 || res_if.res_count !== 4'd0) begin
      n_err++;
      $display("FAIL rst_data: got step=%0d count=%0d, required 0 0", res_if.res_step, res_if.res_count);
    end
    n_vec++;
    if ({sat_busy, sat_sel_dac, sat_if.res_valid} !== 3'b010) begin
      n_err++;
      $display("FAIL rst_sat: got %b, required 010", {sat_busy, sat_sel_dac, sat_if.res_valid});
    end
    resn = 1'b1;
    tick();
  endtask

  task automatic test_sweep();
    bit ok;
    res_if.res_ready = 1'b1; hit_mode = 1;
    sb_q.push_back({4'd1, 4'd4}); sb_q.push_back({4'd2, 4'd4}); sb_q.push_back({4'd3, 4'd4});
    start = 1'b1; tick(); start = 1'b0;
    n_vec++;
    if ({resdac, loaddac, busy} !== 3'b101) begin
      n_err++; $display("FAIL t1_resdac: got resdac/loaddac/busy=%b, required 101", {resdac, loaddac, busy});
    end
    tick();
    n_vec++;
    if ({resdac, loaddac} !== 2'b01) begin
      n_err++; $display("FAIL t1_loaddac: got resdac/loaddac=%b, required 01", {resdac, loaddac});
    end
    wait_sig(1, ok);
    n_vec++;
    if (ok !== 1'b1) begin
      n_err++; $display("FAIL t1_done_wait: got timeout, required done pulse");
    end
    n_vec++;
    if (cyc !== last_acc + 1) begin
      n_err++; $display("FAIL t1_done_time: got cycle %0d, required %0d", cyc, last_acc + 1);
    end
    n_vec++;
    if (sb_q.size() !== 0) begin
      n_err++; $display("FAIL t1_results: got %0d outstanding, required 0", sb_q.size());
    end
    tick();
`ifdef DACSWEEP_LOOP_EN
    n_vec++;
    if ({resdac, busy} !== 2'b11) begin
      n_err++; $display("FAIL t1_loop_clr: got resdac/busy=%b, required 11", {resdac, busy});
    end
    sb_q.push_back({4'd1, 4'd4});
    wait_sig(0, ok);
    wait_sig(0, ok);
    abort = 1'b1; tick(); abort = 1'b0;
    n_vec++;
    if (busy !== 1'b0 || sb_q.size() !== 0) begin
      n_err++; $display("FAIL t1_loop_restart: got busy=%b outstanding=%0d, required 0 0", busy, sb_q.size());
    end
`else
    n_vec++;
    if ({busy, done, resdac} !== 3'b000) begin
      n_err++; $display("FAIL t1_idle: got busy/done/resdac=%b, required 000", {busy, done, resdac});
    end
`endif
    hit_mode = 0;
  endtask

  task automatic test_level();
    bit ok;
    res_if.res_ready = 1'b1; hit_mode = 0;
    sb_q.push_back({4'd1, 4'd1}); sb_q.push_back({4'd2, 4'd0}); sb_q.push_back({4'd3, 4'd4});
    start = 1'b1; tick(); start = 1'b0;
    wait_sig(0, ok);
    tick();
    n_vec++;
    if (sel_dac !== 1'b1) begin
      n_err++; $display("FAIL t2_sel_settle: got %b, required 1", sel_dac);
    end
    tick(); tick();
    n_vec++;
    if (sel_dac !== 1'b0) begin
      n_err++; $display("FAIL t2_sel_meas: got %b, required 0", sel_dac);
    end
    hit_mode = 2;
    wait_sig(0, ok);
    wait_sig(0, ok);
    hit_mode = 1;
    wait_sig(1, ok);
    n_vec++;
    if (ok !== 1'b1 || sb_q.size() !== 0) begin
      n_err++; $display("FAIL t2_level: got done=%b outstanding=%0d, required 1 0", ok, sb_q.size());
    end
    hit_mode = 0;
    end_sweep();
  endtask

  task automatic test_saturate();
    bit ok;
    sat_if.res_ready = 1'b1; hit_mode = 1;
    sat_start = 1'b1; tick(); sat_start = 1'b0;
    wait_sig(3, ok);
    n_vec++;
    if (ok !== 1'b1 || sat_if.res_count !== 4'd15 || sat_if.res_step !== 4'd1) begin
      n_err++;
      $display("FAIL t3_saturate: got valid=%b step=%0d count=%0d, required 1 1 15", ok, sat_if.res_step, sat_if.res_count);
    end
    tick();
    sat_abort = 1'b1; tick(); sat_abort = 1'b0;
    hit_mode = 0;
  endtask

  task automatic test_stall();
    bit ok;
    bit bad;
    res_if.res_ready = 1'b0; hit_mode = 1; bad = 1'b0;
    sb_q.push_back({4'd1, 4'd4}); sb_q.push_back({4'd2, 4'd4}); sb_q.push_back({4'd3, 4'd4});
    start = 1'b1; tick(); start = 1'b0;
    wait_sig(2, ok);
    for (int i = 0; i < 10; i++) begin
      tick();
      n_vec++;
      if ({res_if.res_valid, loaddac, res_if.res_step, res_if.res_count} !== {2'b10, 4'd1, 4'd4}) begin
        n_err++;
        $display("FAIL t4_stall: got valid=%b load=%b step=%0d count=%0d, required 1 0 1 4",
                 res_if.res_valid, loaddac, res_if.res_step, res_if.res_count);
      end
    end
    res_if.res_ready = 1'b1;
    tick();
    n_vec++;
    if ({loaddac, res_if.res_valid} !== 2'b10) begin
      n_err++; $display("FAIL t4_release: got load/valid=%b, required 10", {loaddac, res_if.res_valid});
    end
    wait_sig(1, ok);
    n_vec++;
    if (ok !== 1'b1 || sb_q.size() !== 0) begin
      n_err++; $display("FAIL t4_finish: got done=%b outstanding=%0d, required 1 0", ok, sb_q.size());
    end
    hit_mode = 0;
    end_sweep();
  endtask

  task automatic test_abort();
    bit ok;
    bit seen;
    res_if.res_ready = 1'b1; hit_mode = 1; seen = 1'b0;
    sb_q.push_back({4'd1, 4'd4});
    start = 1'b1; tick(); start = 1'b0;
    wait_sig(0, ok);
    tick();
    start = 1'b1; tick(); start = 1'b0;
    n_vec++;
    if ({resdac, loaddac, busy} !== 3'b001) begin
      n_err++; $display("FAIL t5_start_busy: got resdac/loaddac/busy=%b, required 001", {resdac, loaddac, busy});
    end
    wait_sig(0, ok);
    repeat (4) tick();
    abort = 1'b1; tick(); abort = 1'b0;
    n_vec++;
    if ({busy, res_if.res_valid, sel_dac} !== 3'b001) begin
      n_err++; $display("FAIL t5_abort_meas: got busy/valid/sel=%b, required 001", {busy, res_if.res_valid, sel_dac});
    end
    for (int i = 0; i < 30; i++) begin
      tick();
      if (done === 1'b1 || loaddac === 1'b1 || busy === 1'b1) seen = 1'b1;
    end
    n_vec++;
    if (seen !== 1'b0 || sb_q.size() !== 0) begin
      n_err++; $display("FAIL t5_after_abort: got activity=%b outstanding=%0d, required 0 0", seen, sb_q.size());
    end
    start = 1'b1; tick(); start = 1'b0;
    wait_sig(2, ok);
    abort = 1'b1; tick(); abort = 1'b0;
    n_vec++;
    if ({res_if.res_valid, busy, loaddac, done} !== 4'b0000) begin
      n_err++;
      $display("FAIL t5_abort_report: got valid/busy/load/done=%b, required 0000", {res_if.res_valid, busy, loaddac, done});
    end
    hit_mode = 0;
  endtask

  task automatic test_reset_mid();
    bit ok;
    res_if.res_ready = 1'b1; hit_mode = 1;
    start = 1'b1; tick(); start = 1'b0;
    wait_sig(0, ok);
    tick();
    resn = 1'b0;
    tick();
    n_vec++;
    if ({resdac, loaddac, sel_dac, busy, done, res_if.res_valid} !== 6'b001000 ||
        res_if.res_step !== 4'd0 || res_if.res_count !== 4'd0) begin
      n_err++;
      $display("FAIL t6_reset_mid: got ctrl=%b step=%0d count=%0d, required 001000 0 0",
               {resdac, loaddac, sel_dac, busy, done, res_if.res_valid}, res_if.res_step, res_if.res_count);
    end
    resn = 1'b1;
    tick(); tick();
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++; $display("FAIL t6_idle: got busy=%b, required 0", busy);
    end
    hit_mode = 0;
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_level();
    test_saturate();
    test_stall();
    test_abort();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
